// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   state_t          - controller FSM states
//   X0_IDX           - register index of the hardwired zero register
//   MEM_TIMEOUT_DEF  - default consecutive memory-stall limit
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] X0_IDX          = 5'd0;
    localparam int         MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// perf_counter: enable-driven, wrapping event counter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : count this cycle
//   o_cnt          : current count, wraps modulo 2^CNT_W
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stage-register sequencing for the 5-stage RV32I pipeline.
// Resolves, in priority order: data-memory wait states, multi-cycle mul/div,
// taken-branch flushes and load-use stalls. All controls are Mealy outputs.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   id_rs1/rs2_addr, id_uses_rs1/2  : sources read by the ID instruction
//   ID_EX_memRead, ID_EX_rd         : EX instruction is a load / its rd
//   ex_branch_taken                 : EX redirects the PC
//   ex_md_valid, md_done            : mul/div in EX / result-valid pulse
//   mem_req, mem_ready              : MEM access pending / completing
//   *_write, *_flush                : stage register load / bubble controls
//   md_start                        : one-cycle start pulse to mul/div
//   mem_timeout                     : sticky memory-stall timeout flag
//   stall_cnt, flush_cnt            : performance counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ID_EX_memRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_md_valid,
    input  logic             md_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             MEM_WB_flush,
    output logic             md_start,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int             MW_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MW_W-1:0] MW_MAX = MW_W'(MEM_TIMEOUT);

    state_t          r_state, w_state_nxt;
    logic            r_done_pend;
    logic [MW_W-1:0] r_mw_cnt, w_mw_nxt;
    logic            r_mem_timeout;

    logic w_mem_stall, w_load_use, w_done_any;
    logic w_pend_set, w_pend_clr, w_flush_evt;

    assign w_mem_stall = mem_req && !mem_ready;
    assign w_done_any  = md_done || r_done_pend;
    assign w_load_use  = ID_EX_memRead && (ID_EX_rd != X0_IDX) &&
                         ((ID_EX_rd == id_rs1_addr && id_uses_rs1) ||
                          (ID_EX_rd == id_rs2_addr && id_uses_rs2));

    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        md_start     = 1'b0;
        w_state_nxt  = r_state;
        w_pend_set   = 1'b0;
        w_pend_clr   = 1'b0;
        w_flush_evt  = 1'b0;

        if (!rst_n) begin
            // Hold every stage and load bubbles everywhere while in reset.
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            MEM_WB_flush = 1'b1;
        end else if (w_mem_stall) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_flush = 1'b1;
            // A completion we cannot act on yet is remembered for later.
            w_pend_set   = (r_state == MD_WAIT) && md_done;
        end else if (r_state == RUN && ex_md_valid) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_flush = 1'b1;
            md_start     = 1'b1;
            w_state_nxt  = MD_WAIT;
        end else if (r_state == MD_WAIT && !w_done_any) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_flush = 1'b1;
        end else if (r_state == MD_WAIT) begin
            w_pend_clr   = 1'b1;
            w_state_nxt  = RUN;
        end else if (ex_branch_taken) begin
            // Branch wins over load-use: the dependent instruction is squashed.
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            w_flush_evt  = 1'b1;
        end else if (w_load_use) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_flush  = 1'b1;
        end
    end

    assign w_mw_nxt = !w_mem_stall      ? '0 :
                      (r_mw_cnt == MW_MAX) ? r_mw_cnt : r_mw_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_done_pend   <= 1'b0;
            r_mw_cnt      <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mw_cnt <= w_mw_nxt;
            if (w_pend_set)      r_done_pend <= 1'b1;
            else if (w_pend_clr) r_done_pend <= 1'b0;
            if (w_mem_stall && w_mw_nxt == MW_MAX) r_mem_timeout <= 1'b1;
        end
    end

    assign mem_timeout = r_mem_timeout;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (!pc_write),
        .o_cnt   (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (w_flush_evt),
        .o_cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scenario tasks drive a per-cycle stimulus table, push the
// expected control vector into a scoreboard queue and pop it for comparison
// at the following negedge, once the Mealy outputs have settled.
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    // control vector: {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, memwb_f, md_start}
    localparam logic [8:0] C_NORM  = 9'b1111_0000_0;
    localparam logic [8:0] C_LU    = 9'b0011_0100_0;
    localparam logic [8:0] C_BR    = 9'b1111_1100_0;
    localparam logic [8:0] C_MDST  = 9'b0001_0010_1;
    localparam logic [8:0] C_MDFZ  = 9'b0001_0010_0;
    localparam logic [8:0] C_MEMST = 9'b0000_0001_0;
    localparam logic [8:0] C_RST   = 9'b0000_1111_0;

    // stimulus vector: {mem_req, mem_ready, ex_md_valid, md_done, ex_branch_taken, memRead, uses_rs1, uses_rs2}
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, ID_EX_rd = '0;
    logic id_uses_rs1 = 0, id_uses_rs2 = 0, ID_EX_memRead = 0;
    logic ex_branch_taken = 0, ex_md_valid = 0, md_done = 0, mem_req = 0, mem_ready = 0;
    logic pc_write, IF_ID_write, ID_EX_write, EX_MEM_write;
    logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, md_start, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic [8:0] w_ctrl;
    assign w_ctrl = {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
                     IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, md_start};

    int n_chk  = 0;
    int n_pass = 0;
    logic [8:0] sb_q[$];

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ID_EX_memRead(ID_EX_memRead), .ID_EX_rd(ID_EX_rd),
        .ex_branch_taken(ex_branch_taken), .ex_md_valid(ex_md_valid),
        .md_done(md_done), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
        .EX_MEM_write(EX_MEM_write), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush), .md_start(md_start),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic [7:0] v);
        {mem_req, mem_ready, ex_md_valid, md_done, ex_branch_taken,
         ID_EX_memRead, id_uses_rs1, id_uses_rs2} = v;
    endtask

    task automatic do_reset();
        apply(8'h00);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_chk++;
        if (w_ctrl !== C_RST) $display("FAIL reset ctrl: got %b want %b", w_ctrl, C_RST);
        else n_pass++;
        n_chk++;
        if ({mem_timeout, stall_cnt, flush_cnt} !== '0)
            $display("FAIL reset regs: got to=%b st=%0d fl=%0d want 0", mem_timeout, stall_cnt, flush_cnt);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        logic [7:0] stim [5] = '{8'h05, 8'h00, 8'h05, 8'h06, 8'h04};
        logic [4:0] rd     [5] = '{5'd5, 5'd5, 5'd0, 5'd7, 5'd7};
        logic [8:0] expv   [5] = '{C_LU, C_NORM, C_NORM, C_LU, C_NORM};
        do_reset();
        id_rs1_addr = 5'd7;
        id_rs2_addr = 5'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ID_EX_rd = rd[i];
            apply(stim[i]);
            if (i == 2) id_rs2_addr = 5'd0;   // rd = x0 with matching rs2
            sb_q.push_back(expv[i]);
            @(negedge clk);
            n_chk++;
            if (w_ctrl !== sb_q[0]) $display("FAIL loaduse[%0d]: got %b want %b", i, w_ctrl, sb_q[0]);
            else n_pass++;
            void'(sb_q.pop_front());
        end
        @(posedge clk); #1;
        apply(8'h00);
        n_chk++;
        if (stall_cnt !== 2) $display("FAIL loaduse stall_cnt: got %0d want 2", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_branch_loaduse();
        logic [7:0] stim [2] = '{8'h0D, 8'h00};
        logic [8:0] expv [2] = '{C_BR, C_NORM};
        do_reset();
        ID_EX_rd = 5'd5; id_rs2_addr = 5'd5;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            apply(stim[i]);
            sb_q.push_back(expv[i]);
            @(negedge clk);
            n_chk++;
            if (w_ctrl !== sb_q[0]) $display("FAIL branch[%0d]: got %b want %b", i, w_ctrl, sb_q[0]);
            else n_pass++;
            void'(sb_q.pop_front());
        end
        @(posedge clk); #1;
        n_chk++;
        if (flush_cnt !== 1 || stall_cnt !== 0)
            $display("FAIL branch cnts: got fl=%0d st=%0d want fl=1 st=0", flush_cnt, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_muldiv();
        logic [7:0] stim [7] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h30, 8'h08};
        logic [8:0] expv [7] = '{C_MDST, C_MDFZ, C_MDFZ, C_MDFZ, C_MDFZ, C_NORM, C_BR};
        int starts = 0;
        do_reset();
        ID_EX_rd = 5'd0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            apply(stim[i]);
            sb_q.push_back(expv[i]);
            @(negedge clk);
            starts += int'(md_start);
            n_chk++;
            if (w_ctrl !== sb_q[0]) $display("FAIL muldiv[%0d]: got %b want %b", i, w_ctrl, sb_q[0]);
            else n_pass++;
            void'(sb_q.pop_front());
        end
        @(posedge clk); #1;
        apply(8'h00);
        n_chk++;
        if (stall_cnt !== 5 || starts != 1)
            $display("FAIL muldiv cnts: got st=%0d starts=%0d want st=5 starts=1", stall_cnt, starts);
        else n_pass++;
    endtask

    task automatic test_done_in_memstall();
        logic [7:0] stim [8] = '{8'h20, 8'h20, 8'hA0, 8'hB0, 8'hA0, 8'hE0, 8'h08, 8'h20};
        logic [8:0] expv [8] = '{C_MDST, C_MDFZ, C_MEMST, C_MEMST, C_MEMST, C_NORM, C_BR, C_MDST};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            apply(stim[i]);
            sb_q.push_back(expv[i]);
            @(negedge clk);
            n_chk++;
            if (w_ctrl !== sb_q[0]) $display("FAIL donepend[%0d]: got %b want %b", i, w_ctrl, sb_q[0]);
            else n_pass++;
            void'(sb_q.pop_front());
        end
        @(posedge clk); #1;
        apply(8'h00);
        n_chk++;
        if (stall_cnt !== 6 || mem_timeout !== 1'b0)
            $display("FAIL donepend cnts: got st=%0d to=%b want st=6 to=0", stall_cnt, mem_timeout);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            apply(i < 6 ? 8'h80 : 8'hC0);
            sb_q.push_back(i < 6 ? C_MEMST : C_NORM);
            @(negedge clk);
            n_chk++;
            if (w_ctrl !== sb_q[0] || mem_timeout !== (i >= 4))
                $display("FAIL timeout[%0d]: got %b to=%b want %b to=%b",
                         i, w_ctrl, mem_timeout, sb_q[0], (i >= 4));
            else n_pass++;
            void'(sb_q.pop_front());
        end
        apply(8'h00);
    endtask

    task automatic test_reset_mid_md();
        logic [7:0] stim [3] = '{8'h00, 8'h08, 8'h20};
        logic [8:0] expv [3] = '{C_NORM, C_BR, C_MDST};
        // mem_timeout is still set from the previous scenario.
        @(posedge clk); #1; apply(8'h20);
        @(posedge clk); #1; apply(8'h20);
        @(negedge clk);
        n_chk++;
        if (w_ctrl !== C_MDFZ) $display("FAIL midreset pre: got %b want %b", w_ctrl, C_MDFZ);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (w_ctrl !== C_RST || mem_timeout !== 1'b0 || stall_cnt !== 0)
            $display("FAIL midreset async: got %b to=%b st=%0d want %b to=0 st=0",
                     w_ctrl, mem_timeout, stall_cnt, C_RST);
        else n_pass++;
        apply(8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            apply(stim[i]);
            sb_q.push_back(expv[i]);
            @(negedge clk);
            n_chk++;
            if (w_ctrl !== sb_q[0]) $display("FAIL midreset[%0d]: got %b want %b", i, w_ctrl, sb_q[0]);
            else n_pass++;
            void'(sb_q.pop_front());
        end
        apply(8'h00);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_loaduse();
        test_muldiv();
        test_done_in_memstall();
        test_timeout();
        test_reset_mid_md();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
